// File: rtl/ip_tx_arbiter.sv
// ip_tx_arbiter: round-robin sharing of one ip_packet_tx engine among NUM_REQ requesters,
// latching the winner's fields and reporting done/error back to it.
module ip_tx_arbiter #(
    parameter int NUM_REQ       = 2,
    parameter int START_TIMEOUT = 8,
    parameter int IDX_W         = $clog2(NUM_REQ)
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [NUM_REQ-1:0]    REQ_VALID,
    input  logic [32*NUM_REQ-1:0] REQ_IP_ADDRESS,
    input  logic [48*NUM_REQ-1:0] REQ_MAC_ADDRESS,
    input  logic [10*NUM_REQ-1:0] REQ_MESSAGE,
    output logic [NUM_REQ-1:0]    REQ_DONE,
    output logic                  REQ_ERROR,
    output logic [IDX_W-1:0]      GRANT_IDX,
    output logic                  BUSY,
    output logic [31:0]           TX_RECIPIENT_IP_ADDRESS,
    output logic [47:0]           TX_RECIPIENT_MAC_ADDRESS,
    output logic [9:0]            TX_RECIPIENT_MESSAGE,
    output logic                  TX_START_IP_TXN,
    input  logic                  TX_READY_FOR_SEND,
    output logic [15:0]           SENT_COUNT
);
    localparam int TW = $clog2(START_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_IDLE, DONE} state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] cand;
    logic [TW-1:0]    cnt;
    logic             err;

    // Descending scan so the candidate closest to ptr overwrites the others.
    always_comb begin
        sel  = ptr;
        cand = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = IDX_W'((32'(ptr) + 32'(k)) % NUM_REQ);
            if (REQ_VALID[cand]) sel = cand;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESET) begin
            state                    <= IDLE;
            ptr                      <= '0;
            cnt                      <= '0;
            err                      <= 1'b0;
            REQ_DONE                 <= '0;
            REQ_ERROR                <= 1'b0;
            GRANT_IDX                <= '0;
            BUSY                     <= 1'b0;
            TX_RECIPIENT_IP_ADDRESS  <= '0;
            TX_RECIPIENT_MAC_ADDRESS <= '0;
            TX_RECIPIENT_MESSAGE     <= '0;
            TX_START_IP_TXN          <= 1'b0;
            SENT_COUNT               <= '0;
        end else begin
            TX_START_IP_TXN <= 1'b0;
            REQ_DONE        <= '0;
            REQ_ERROR       <= 1'b0;
            case (state)
                IDLE: if (|REQ_VALID && TX_READY_FOR_SEND) begin
                    GRANT_IDX                <= sel;
                    TX_RECIPIENT_IP_ADDRESS  <= REQ_IP_ADDRESS[32*sel +: 32];
                    TX_RECIPIENT_MAC_ADDRESS <= REQ_MAC_ADDRESS[48*sel +: 48];
                    TX_RECIPIENT_MESSAGE     <= REQ_MESSAGE[10*sel +: 10];
                    TX_START_IP_TXN          <= 1'b1;
                    BUSY                     <= 1'b1;
                    state                    <= START;
                end
                START: begin
                    cnt   <= '0;
                    err   <= 1'b0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (!TX_READY_FOR_SEND) begin
                        state <= WAIT_IDLE;
                    end else if (cnt == TW'(START_TIMEOUT - 1)) begin
                        err       <= 1'b1;
                        REQ_DONE  <= NUM_REQ'(1) << GRANT_IDX;
                        REQ_ERROR <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + TW'(1);
                    end
                end
                WAIT_IDLE: if (TX_READY_FOR_SEND) begin
                    REQ_DONE <= NUM_REQ'(1) << GRANT_IDX;
                    state    <= DONE;
                end
                DONE: begin
                    ptr        <= (GRANT_IDX == IDX_W'(NUM_REQ - 1)) ? '0 : GRANT_IDX + IDX_W'(1);
                    SENT_COUNT <= err ? SENT_COUNT : SENT_COUNT + 16'd1;
                    BUSY       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ip_tx_arbiter.sv
// tb_ip_tx_arbiter: randomized requesters and tx engine against a transaction-level model
// that predicts grant order, latched fields, start/done cycles and the sent count.
module tb_ip_tx_arbiter;
    localparam int N  = 2;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic [N-1:0]  valid;
    logic [31:0]   ip  [N];
    logic [47:0]   mac [N];
    logic [9:0]    msg [N];
    logic [32*N-1:0] ip_bus;
    logic [48*N-1:0] mac_bus;
    logic [10*N-1:0] msg_bus;
    logic          ready;
    logic [N-1:0]  done;
    logic          error;
    logic [0:0]    grant;
    logic          busy;
    logic [31:0]   tx_ip;
    logic [47:0]   tx_mac;
    logic [9:0]    tx_msg;
    logic          start;
    logic [15:0]   sent;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    always_comb begin
        ip_bus  = '0;
        mac_bus = '0;
        msg_bus = '0;
        for (int i = 0; i < N; i++) begin
            ip_bus[32*i +: 32]  = ip[i];
            mac_bus[48*i +: 48] = mac[i];
            msg_bus[10*i +: 10] = msg[i];
        end
    end

    ip_tx_arbiter #(.NUM_REQ(N), .START_TIMEOUT(TO)) dut (
        .ACLK(clk), .ARESET(rstn), .REQ_VALID(valid),
        .REQ_IP_ADDRESS(ip_bus), .REQ_MAC_ADDRESS(mac_bus), .REQ_MESSAGE(msg_bus),
        .REQ_DONE(done), .REQ_ERROR(error), .GRANT_IDX(grant), .BUSY(busy),
        .TX_RECIPIENT_IP_ADDRESS(tx_ip), .TX_RECIPIENT_MAC_ADDRESS(tx_mac),
        .TX_RECIPIENT_MESSAGE(tx_msg), .TX_START_IP_TXN(start),
        .TX_READY_FOR_SEND(ready), .SENT_COUNT(sent)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic new_fields(input int i);
        ip[i]  = $urandom;
        mac[i] = {16'($urandom), 32'($urandom)};
        msg[i] = 10'($urandom);
    endtask

    bit          m_busy, m_err, released;
    int          m_ptr, m_owner, m_start, m_done, eng_low, eng_high, rel_idx, n_mid;
    logic [15:0] m_sent;
    logic [31:0] e_ip;
    logic [47:0] e_mac;
    logic [9:0]  e_msg;

    task automatic model_reset();
        m_busy = 0; m_err = 0; released = 0;
        m_ptr = 0; m_owner = 0; m_start = -1; m_done = -1;
        eng_low = -1; eng_high = -1; m_sent = '0;
        e_ip = '0; e_mac = '0; e_msg = '0;
    endtask

    initial begin
        bit mid_rst, fair;
        int w, d;
        rstn  = 1'b0;
        ready = 1'b1;
        valid = 2'b01;
        ip[0] = 32'hdeadbeef; mac[0] = 48'h32dabbadebd5; msg[0] = 10'h1ff;
        ip[1] = '0; mac[1] = '0; msg[1] = '0;
        n_mid = 0;
        model_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk);
            #1;
            fair = (cyc >= 200 && cyc < 600);
            mid_rst = m_busy && !m_err && cyc > 300 && cyc >= eng_low + 1 && cyc < eng_high
                      && n_mid < 3 && $urandom_range(4) == 0;
            if (mid_rst) n_mid++;
            rstn  = !(cyc < 3 || mid_rst);
            ready = m_busy ? !(cyc >= eng_low && cyc < eng_high) : ($urandom_range(99) >= 15);
            for (int i = 0; i < N; i++) begin
                if (released && i == rel_idx) begin
                    valid[i] = fair || $urandom_range(1) == 1;
                    if (valid[i]) new_fields(i);
                end else if (m_busy && i == m_owner) begin
                    if ($urandom_range(9) == 0) valid[i] = 1'b0;
                    if ($urandom_range(2) == 0) new_fields(i);
                end else if (!valid[i]) begin
                    if (fair || $urandom_range(99) < 25) begin
                        valid[i] = 1'b1;
                        new_fields(i);
                    end
                end else if (!fair && $urandom_range(99) < 3) begin
                    valid[i] = 1'b0;
                end
            end
            released = 0;
            @(negedge clk);
            check("start", 64'(start), 64'(cyc == m_start));
            check("done", 64'(done), (m_busy && cyc == m_done) ? 64'(1) << m_owner : 64'(0));
            check("error", 64'(error), 64'(m_busy && cyc == m_done && m_err));
            check("busy", 64'(busy), 64'(m_busy));
            check("grant", 64'(grant), 64'(m_owner));
            check("tx_ip", 64'(tx_ip), 64'(e_ip));
            check("tx_mac", 64'(tx_mac), 64'(e_mac));
            check("tx_msg", 64'(tx_msg), 64'(e_msg));
            check("sent", 64'(sent), 64'(m_sent));
            if (!rstn) begin
                model_reset();
            end else if (m_busy && cyc == m_done) begin
                m_busy   = 0;
                m_ptr    = (m_owner + 1) % N;
                m_sent   = m_err ? m_sent : m_sent + 16'd1;
                released = 1;
                rel_idx  = m_owner;
            end else if (!m_busy && ready && |valid) begin
                w = -1;
                for (int k = 0; k < N; k++)
                    if (w < 0 && valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                m_owner = w;
                e_ip = ip[w]; e_mac = mac[w]; e_msg = msg[w];
                m_busy  = 1;
                m_start = cyc + 1;
                if ($urandom_range(99) < 20) begin
                    m_err = 1; eng_low = -1; eng_high = -1;
                    m_done = cyc + 2 + TO;
                end else begin
                    m_err = 0;
                    d = $urandom_range(3);
                    eng_low  = cyc + 2 + d;
                    eng_high = eng_low + 1 + $urandom_range(3);
                    m_done   = eng_high + 1;
                end
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
